// File: rtl/riscv_lsu_if.sv
// Core-side request/response and RAM data-port signals of the load/store unit.
// master = core + RAM environment, slave = the LSU itself.
interface riscv_lsu_if #(
  parameter int unsigned WORD_LENGTH = 32
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [2:0]             req_funct3;
  logic [WORD_LENGTH-1:0] req_addr;
  logic [WORD_LENGTH-1:0] req_wdata;
  logic                   rsp_valid;
  logic [WORD_LENGTH-1:0] rsp_rdata;
  logic                   rsp_err;
  logic [WORD_LENGTH-1:0] mem_addr;
  logic                   mem_write_en;
  logic [WORD_LENGTH-1:0] mem_wdata;
  logic [WORD_LENGTH-1:0] mem_dout;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_write_en, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_write_en, mem_wdata
  );
endinterface

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: word-aligned RAM accesses, read-modify-write for SB/SH,
// sign/zero extension for loads, one request in flight.
module riscv_lsu #(
  parameter int unsigned WORD_LENGTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  riscv_lsu_if.slave  bus
);

  localparam int unsigned W = 32;
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW,
    S_WRITE,
    S_RESP
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_addr;
  logic [2:0]     r_funct3;
  logic [W-1:0]   r_rdata;
  logic           r_req_ready;
  logic           r_rsp_valid;
  logic           r_rsp_err;
  logic           r_mem_we;
  // Holds the store data from accept; replaced by the merged word for SB/SH.
  logic [W-1:0]   r_mem_wdata;

  logic           w_is_half;
  logic           w_is_word;
  logic           w_f3_ok;
  logic           w_aligned;
  logic           w_legal;
  logic [4:0]     w_bsh;
  logic [4:0]     w_hsh;
  logic [15:0]    w_lane;
  logic [W-1:0]   w_load_ext;
  logic [W-1:0]   w_mask;
  logic [W-1:0]   w_ins;
  logic [W-1:0]   w_merged;

  // Request legality, evaluated on the live request at accept time.
  always_comb begin
    w_is_half = (bus.req_funct3[1:0] == 2'b01);
    w_is_word = (bus.req_funct3 == F3_W);
    w_f3_ok   = bus.req_we ? (bus.req_funct3 <= F3_W)
                           : ((bus.req_funct3 != 3'd3) && (bus.req_funct3 <= F3_HU));
    w_aligned = !(w_is_half && bus.req_addr[0]) &&
                !(w_is_word && (bus.req_addr[1:0] != 2'b00));
    w_legal   = w_f3_ok && w_aligned;
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    w_bsh  = {r_addr[1:0], 3'b000};
    w_hsh  = {r_addr[1], 4'b0000};
    w_lane = 16'(bus.mem_dout >> w_bsh);
    unique case (r_funct3)
      F3_B:    w_load_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      F3_H:    w_load_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      F3_W:    w_load_ext = bus.mem_dout;
      F3_BU:   w_load_ext = {24'd0, w_lane[7:0]};
      F3_HU:   w_load_ext = {16'd0, w_lane[15:0]};
      default: w_load_ext = '0;
    endcase
    if (r_funct3[0]) begin
      w_mask = 32'h0000_FFFF << w_hsh;
      w_ins  = {16'd0, r_mem_wdata[15:0]} << w_hsh;
    end else begin
      w_mask = 32'h0000_00FF << w_bsh;
      w_ins  = {24'd0, r_mem_wdata[7:0]} << w_bsh;
    end
    w_merged = (bus.mem_dout & ~w_mask) | w_ins;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_funct3    <= '0;
      r_rdata     <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_addr      <= bus.req_addr;
            r_funct3    <= bus.req_funct3;
            r_mem_wdata <= bus.req_wdata;
            r_rdata     <= '0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b0;
            if (!w_legal) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else if (!bus.req_we) begin
              r_state <= S_LOAD;
            end else if (w_is_word) begin
              r_state  <= S_WRITE;
              r_mem_we <= 1'b1;
            end else begin
              r_state <= S_RMW;
            end
          end
        end
        S_LOAD: begin
          r_rdata     <= w_load_ext;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RMW: begin
          r_mem_wdata <= w_merged;
          r_mem_we    <= 1'b1;
          r_state     <= S_WRITE;
        end
        S_WRITE: begin
          r_mem_we    <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_mem_we    <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready    = r_req_ready;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_rdata    = r_rdata;
  assign bus.rsp_err      = r_rsp_err;
  assign bus.mem_addr     = {r_addr[W-1:2], 2'b00};
  assign bus.mem_write_en = r_mem_we;
  assign bus.mem_wdata    = r_mem_wdata;

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: 64-word RAM model, directed and random loads/stores
// checked against an arithmetic reference of RV32I load/store semantics.
module tb_riscv_lsu;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  riscv_lsu_if bus_if ();
  riscv_lsu dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

  logic [31:0] ram  [0:63];
  logic [31:0] gold [0:63];
  logic        tb_we;
  logic [5:0]  tb_idx;
  logic [31:0] tb_val;

  assign bus_if.mem_dout = ram[bus_if.mem_addr[7:2]];

  always @(posedge clk) begin
    if (bus_if.mem_write_en) ram[bus_if.mem_addr[7:2]] <= bus_if.mem_wdata;
    else if (tb_we)          ram[tb_idx] <= tb_val;
  end

  int vectors = 0;
  int miscompares = 0;

  function automatic logic model_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (we && f3 > 3'd2) return 1'b0;
    if (!we && (f3 == 3'd3 || f3 > 3'd5)) return 1'b0;
    sz = (f3 == 3'd2) ? 4 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 1);
    return (int'(a[1:0]) % sz) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [31:0] a);
    longint w, v;
    w = longint'({32'd0, word});
    v = w / (longint'(1) << (8 * int'(a[1:0])));
    case (f3)
      3'd0: begin v = v % 256;   return (v >= 128)   ? 32'(v - 256)   : 32'(v); end
      3'd1: begin v = v % 65536; return (v >= 32768) ? 32'(v - 65536) : 32'(v); end
      3'd2: return word;
      3'd4: return 32'(v % 256);
      3'd5: return 32'(v % 65536);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [2:0] f3,
                                              input logic [31:0] a, input logic [31:0] wd);
    logic [7:0] b [4];
    logic [31:0] res;
    int n, off;
    for (int k = 0; k < 4; k++) b[k] = old[8*k +: 8];
    n   = (f3 == 3'd0) ? 1 : ((f3 == 3'd1) ? 2 : 4);
    off = int'(a[1:0]);
    for (int k = 0; k < n; k++) b[off + k] = wd[8*k +: 8];
    res = {b[3], b[2], b[1], b[0]};
    return res;
  endfunction

  function automatic int model_latency(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (!model_legal(we, f3, a)) return 1;
    if (!we || f3 == 3'd2) return 2;
    return 3;
  endfunction

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    tb_we = 1'b1; tb_idx = 6'(idx); tb_val = val;
    @(posedge clk); #1;
    tb_we = 1'b0;
    gold[idx] = val;
  endtask

  // Issue one request and observe it until its response pulse (bounded).
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic err, output int wpulses, output int waits,
                        output logic ready_at_rsp);
    lat = -1; rd = '0; err = 1'b0; wpulses = 0; waits = 0; ready_at_rsp = 1'b1;
    @(negedge clk);
    while (!bus_if.req_ready && waits < 20) begin @(negedge clk); waits++; end
    bus_if.req_valid = 1'b1; bus_if.req_we = we; bus_if.req_funct3 = f3;
    bus_if.req_addr = addr; bus_if.req_wdata = wd;
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus_if.mem_write_en) wpulses++;
      if (bus_if.rsp_valid) begin
        lat = c; rd = bus_if.rsp_rdata; err = bus_if.rsp_err; ready_at_rsp = bus_if.req_ready;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    vectors++; if (bus_if.req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got %b want 1", bus_if.req_ready); end
    vectors++; if (bus_if.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b want 0", bus_if.rsp_valid); end
    vectors++; if (bus_if.rsp_rdata !== 32'd0) begin miscompares++; $display("FAIL reset_rsp_rdata got %h want 0", bus_if.rsp_rdata); end
    vectors++; if (bus_if.rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err got %b want 0", bus_if.rsp_err); end
    vectors++; if (bus_if.mem_addr !== 32'd0) begin miscompares++; $display("FAIL reset_mem_addr got %h want 0", bus_if.mem_addr); end
    vectors++; if (bus_if.mem_write_en !== 1'b0) begin miscompares++; $display("FAIL reset_mem_write_en got %b want 0", bus_if.mem_write_en); end
    vectors++; if (bus_if.mem_wdata !== 32'd0) begin miscompares++; $display("FAIL reset_mem_wdata got %h want 0", bus_if.mem_wdata); end
  endtask

  task automatic test_directed;
    int lat, wp, wt; logic [31:0] rd; logic err, rdy;
    poke(4, 32'h8899_AABB);
    do_req(1'b0, 3'd0, 32'h11, 32'd0, lat, rd, err, wp, wt, rdy);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL lb_latency got %0d want 2", lat); end
    vectors++; if (rd !== 32'hFFFF_FFAA) begin miscompares++; $display("FAIL lb_rdata got %h want ffffffaa", rd); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL lb_err got %b want 0", err); end
    do_req(1'b0, 3'd5, 32'h12, 32'd0, lat, rd, err, wp, wt, rdy);
    vectors++; if (rd !== 32'h0000_8899) begin miscompares++; $display("FAIL lhu_rdata got %h want 00008899", rd); end
    do_req(1'b0, 3'd2, 32'h10, 32'd0, lat, rd, err, wp, wt, rdy);
    vectors++; if (rd !== 32'h8899_AABB) begin miscompares++; $display("FAIL lw_rdata got %h want 8899aabb", rd); end
    do_req(1'b1, 3'd0, 32'h13, 32'h1234_5677, lat, rd, err, wp, wt, rdy);
    gold[4] = 32'h7799_AABB;
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL sb_latency got %0d want 3", lat); end
    vectors++; if (wp !== 1) begin miscompares++; $display("FAIL sb_write_pulses got %0d want 1", wp); end
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL sb_rdata got %h want 0", rd); end
    vectors++; if (ram[4] !== 32'h7799_AABB) begin miscompares++; $display("FAIL sb_ram got %h want 7799aabb", ram[4]); end
  endtask

  task automatic test_errors;
    logic        we_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3_t [4] = '{3'd1, 3'd2, 3'd4, 3'd3};
    logic [31:0] ad_t [4] = '{32'h11, 32'h12, 32'h10, 32'h10};
    int lat, wp, wt; logic [31:0] rd; logic err, rdy;
    for (int i = 0; i < 4; i++) begin
      do_req(we_t[i], f3_t[i], ad_t[i], 32'hDEAD_BEEF, lat, rd, err, wp, wt, rdy);
      vectors++; if (lat !== 1) begin miscompares++; $display("FAIL err%0d_latency got %0d want 1", i, lat); end
      vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err%0d_flag got %b want 1", i, err); end
      vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL err%0d_rdata got %h want 0", i, rd); end
      vectors++; if (wp !== 0) begin miscompares++; $display("FAIL err%0d_write_pulses got %0d want 0", i, wp); end
      vectors++; if (ram[4] !== gold[4]) begin miscompares++; $display("FAIL err%0d_ram got %h want %h", i, ram[4], gold[4]); end
    end
  endtask

  task automatic test_random;
    int lat, wp, wt, idx; logic [31:0] rd, a, wd, exp_rd; logic err, rdy, we, legal; logic [2:0] f3;
    for (int n = 0; n < 200; n++) begin
      we  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      a   = (n % 16 == 0) ? $urandom : 32'($urandom_range(0, 255));
      wd  = $urandom;
      idx = int'(a[7:2]);
      legal  = model_legal(we, f3, a);
      exp_rd = (legal && !we) ? model_load(gold[idx], f3, a) : 32'd0;
      do_req(we, f3, a, wd, lat, rd, err, wp, wt, rdy);
      if (legal && we) gold[idx] = model_store(gold[idx], f3, a, wd);
      vectors++; if (lat !== model_latency(we, f3, a)) begin miscompares++; $display("FAIL rnd%0d_latency we=%b f3=%0d a=%h got %0d want %0d", n, we, f3, a, lat, model_latency(we, f3, a)); end
      vectors++; if (err !== !legal) begin miscompares++; $display("FAIL rnd%0d_err we=%b f3=%0d a=%h got %b want %b", n, we, f3, a, err, !legal); end
      vectors++; if (rd !== exp_rd) begin miscompares++; $display("FAIL rnd%0d_rdata we=%b f3=%0d a=%h got %h want %h", n, we, f3, a, rd, exp_rd); end
      vectors++; if (wp !== ((legal && we) ? 1 : 0)) begin miscompares++; $display("FAIL rnd%0d_write_pulses got %0d want %0d", n, wp, (legal && we) ? 1 : 0); end
      vectors++; if (ram[idx] !== gold[idx]) begin miscompares++; $display("FAIL rnd%0d_ram idx=%0d got %h want %h", n, idx, ram[idx], gold[idx]); end
    end
  endtask

  task automatic test_back_to_back;
    int lat, wp, wt; logic [31:0] rd, a; logic err, rdy;
    for (int n = 0; n < 6; n++) begin
      a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      do_req(1'b0, 3'd2, a, 32'd0, lat, rd, err, wp, wt, rdy);
      vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL b2b%0d_ready_in_rsp got %b want 0", n, rdy); end
      vectors++; if (rd !== gold[a[7:2]]) begin miscompares++; $display("FAIL b2b%0d_rdata got %h want %h", n, rd, gold[a[7:2]]); end
      if (n > 0) begin
        vectors++; if (wt !== 0) begin miscompares++; $display("FAIL b2b%0d_ready_wait got %0d want 0", n, wt); end
      end
    end
  endtask

  task automatic test_reset_mid_rmw;
    int lat, wp, wt; logic [31:0] rd; logic err, rdy;
    poke(4, 32'h0123_4567);
    @(negedge clk);
    bus_if.req_valid = 1'b1; bus_if.req_we = 1'b1; bus_if.req_funct3 = 3'd0;
    bus_if.req_addr = 32'h10; bus_if.req_wdata = 32'h0000_00EE;
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++; if (bus_if.req_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_req_ready got %b want 1", bus_if.req_ready); end
    vectors++; if (bus_if.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_rsp_valid got %b want 0", bus_if.rsp_valid); end
    wp = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus_if.mem_write_en) wp++;
    end
    rst_n = 1'b1;
    vectors++; if (wp !== 0) begin miscompares++; $display("FAIL rstmid_write_pulses got %0d want 0", wp); end
    vectors++; if (ram[4] !== 32'h0123_4567) begin miscompares++; $display("FAIL rstmid_ram got %h want 01234567", ram[4]); end
    do_req(1'b0, 3'd2, 32'h10, 32'd0, lat, rd, err, wp, wt, rdy);
    vectors++; if (rd !== 32'h0123_4567) begin miscompares++; $display("FAIL rstmid_reload got %h want 01234567", rd); end
  endtask

  initial begin
    rst_n = 1'b0;
    tb_we = 1'b0; tb_idx = '0; tb_val = '0;
    bus_if.req_valid = 1'b0; bus_if.req_we = 1'b0; bus_if.req_funct3 = '0;
    bus_if.req_addr = '0; bus_if.req_wdata = '0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) poke(i, $urandom);
    test_directed;
    test_errors;
    test_random;
    test_back_to_back;
    test_reset_mid_rmw;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
